// File: rtl/pipe_run_sequencer_if.sv
// Control/status bundle between the pipeline sequencer and the debug/decode logic.
interface pipe_run_sequencer_if #(
    parameter int unsigned PERF_W = 16
);
    logic              start;
    logic              step;
    logic              halt_req;
    logic              jump;
    logic              pc_en;
    logic              if_id_en;
    logic              if_id_flush;
    logic [1:0]        state;
    logic              busy;
    logic [PERF_W-1:0] retired_cnt;
    logic [PERF_W-1:0] squash_cnt;
    logic [PERF_W-1:0] cycle_cnt;

    modport master (
        output start, step, halt_req, jump,
        input  pc_en, if_id_en, if_id_flush, state, busy,
        input  retired_cnt, squash_cnt, cycle_cnt
    );

    modport slave (
        input  start, step, halt_req, jump,
        output pc_en, if_id_en, if_id_flush, state, busy,
        output retired_cnt, squash_cnt, cycle_cnt
    );
endinterface

// File: rtl/pipe_run_sequencer.sv
// Run/halt/single-step sequencer for the 4-stage pipeline: fetch gating, jump squash,
// drain-before-halt, per-stage valid tracking and saturating debug counters.
module pipe_run_sequencer #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned PERF_W = 16
) (
    input logic                 i_clk,
    input logic                 i_rst_n,
    pipe_run_sequencer_if.slave io_seq
);
    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_RUN   = 2'b01;
    localparam logic [1:0] ST_DRAIN = 2'b10;
    localparam logic [1:0] ST_STEP  = 2'b11;

    logic [1:0]        r_state;
    logic [1:0]        w_state_d;
    logic              r_halt_pend;
    logic              w_halt_pend_d;
    logic              w_halt_pend;
    logic [DEPTH-2:0]  r_v;
    logic [PERF_W-1:0] r_retired;
    logic [PERF_W-1:0] r_squash;
    logic [PERF_W-1:0] r_cycle;
    logic              w_pc_en;
    logic              w_squash;
    logic              w_busy;

    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] cnt,
                                                  input logic inc);
        return (inc && (cnt != '1)) ? cnt + PERF_W'(1) : cnt;
    endfunction

    always_comb begin
        w_pc_en  = (r_state == ST_RUN) || (r_state == ST_STEP);
        w_squash = io_seq.jump && r_v[0] && w_pc_en;
        w_busy   = (r_state != ST_IDLE);
    end

    always_comb begin
        io_seq.pc_en       = w_pc_en;
        io_seq.if_id_en    = w_pc_en;
        io_seq.if_id_flush = !w_pc_en || w_squash;
        io_seq.state       = r_state;
        io_seq.busy        = w_busy;
        io_seq.retired_cnt = r_retired;
        io_seq.squash_cnt  = r_squash;
        io_seq.cycle_cnt   = r_cycle;
    end

    always_comb begin
        w_state_d     = r_state;
        w_halt_pend_d = r_halt_pend;
        w_halt_pend   = io_seq.halt_req || r_halt_pend;
        case (r_state)
            ST_IDLE: begin
                if (io_seq.start) begin
                    w_state_d = ST_RUN;
                end else if (io_seq.step) begin
                    w_state_d = ST_STEP;
                end
            end
            ST_RUN: begin
                // A halt racing a taken jump waits one cycle so the target gets fetched.
                if (w_halt_pend) begin
                    if (!w_squash) begin
                        w_state_d     = ST_DRAIN;
                        w_halt_pend_d = 1'b0;
                    end else begin
                        w_halt_pend_d = 1'b1;
                    end
                end
            end
            ST_STEP: begin
                w_state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                // Leave as the oldest valid instruction retires on this edge.
                if (r_v[DEPTH-3:0] == '0) begin
                    w_state_d = ST_IDLE;
                end
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_halt_pend <= 1'b0;
            r_v         <= '0;
            r_retired   <= '0;
            r_squash    <= '0;
            r_cycle     <= '0;
        end else begin
            r_state     <= w_state_d;
            r_halt_pend <= w_halt_pend_d;
            r_v         <= {r_v[DEPTH-3:0], w_pc_en && !w_squash};
            r_retired   <= sat_inc(r_retired, r_v[DEPTH-2]);
            r_squash    <= sat_inc(r_squash, w_squash);
            r_cycle     <= sat_inc(r_cycle, w_busy);
        end
    end
endmodule
